// File: rtl/map_pkg.sv
// Shared types and constants for the MAP decoder frame controller.
// Holds the sequencer state encoding, default address width and LLR pipeline depth.
package map_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFwd,
        StBwd,
        StDone
    } state_e;

    localparam int unsigned AddrWDefault = 6;
    localparam int unsigned LlrLatency   = 1;

endpackage

// File: rtl/map_step_cnt.sv
// Trellis-step counter shared by the load, forward and backward phases.
// Flags the last step of a frame and returns to zero there instead of wrapping.
module map_step_cnt
    import map_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned ADDR_W    = AddrWDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] cnt,
    output logic              term
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(FRAME_LEN - 1);

    assign term = (cnt == LastIdx);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= term ? '0 : cnt + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/map_trellis_ctrl.sv
// Frame sequencer for the MAP datapath: gamma loading, then the alpha sweep, then the
// beta sweep with a delayed LLR strobe. Control only; no metric arithmetic.
module map_trellis_ctrl
    import map_pkg::*;
#(
    parameter int unsigned FRAME_LEN = 64,
    parameter int unsigned ADDR_W    = AddrWDefault
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              gama_we,
    output logic [ADDR_W-1:0] gama_addr,
    output logic              alpha_en,
    output logic [ADDR_W-1:0] alpha_addr,
    output logic              beta_en,
    output logic [ADDR_W-1:0] beta_addr,
    output logic              llr_valid,
    output logic [ADDR_W-1:0] llr_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(FRAME_LEN - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt;
    logic              term;
    logic              cnt_en;
    logic              cnt_clr;

    logic              llr_v_q   [LlrLatency];
    logic [ADDR_W-1:0] llr_idx_q [LlrLatency];

    // Phase strobes decode the state register only; gama_we is the sole input-dependent output.
    assign in_ready = (state_q == StLoad);
    assign alpha_en = (state_q == StFwd);
    assign beta_en  = (state_q == StBwd);
    assign done     = (state_q == StDone);
    assign busy     = (state_q != StIdle);
    assign gama_we  = in_valid & in_ready;

    assign gama_addr  = in_ready ? cnt : '0;
    assign alpha_addr = alpha_en ? cnt : '0;
    assign beta_addr  = beta_en ? LastIdx - cnt : '0;

    assign cnt_en  = gama_we | alpha_en | beta_en;
    assign cnt_clr = (state_q == StIdle);

    map_step_cnt #(
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W)
    ) u_step_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .cnt  (cnt),
        .term (term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_q <= StLoad;
                StLoad:  if (gama_we && term) state_q <= StFwd;
                StFwd:   if (term) state_q <= StBwd;
                StBwd:   if (term) state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // LLR strobe trails the beta step so the last index lands in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LlrLatency; i++) begin
                llr_v_q[i]   <= 1'b0;
                llr_idx_q[i] <= '0;
            end
        end else begin
            llr_v_q[0]   <= beta_en;
            llr_idx_q[0] <= beta_addr;
            for (int i = 1; i < LlrLatency; i++) begin
                llr_v_q[i]   <= llr_v_q[i-1];
                llr_idx_q[i] <= llr_idx_q[i-1];
            end
        end
    end

    assign llr_valid = llr_v_q[LlrLatency-1];
    assign llr_idx   = llr_idx_q[LlrLatency-1];

endmodule
